// File: rtl/commit_packet_arb.sv
`default_nettype none
// ============================================================================
// Module   : commit_packet_arb
// Purpose  : Packet-aware round-robin arbiter. Merges NUM_INPUTS execution
//            unit commit streams onto one writeback stream. A packet that
//            starts without eop holds the grant until its eop beat, so beats
//            of different units never interleave. The output is a single
//            registered elastic stage.
// Revision : 1.0 - initial release
// ============================================================================
module commit_packet_arb #(
    parameter int NUM_INPUTS = 4,
    parameter int DATAW      = 64,
    parameter int SELW       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS-1:0]       valid_in,
    input  logic [NUM_INPUTS*DATAW-1:0] data_in,
    input  logic [NUM_INPUTS-1:0]       sop_in,
    input  logic [NUM_INPUTS-1:0]       eop_in,
    output logic [NUM_INPUTS-1:0]       ready_in,
    output logic                        valid_out,
    output logic [DATAW-1:0]            data_out,
    output logic                        sop_out,
    output logic                        eop_out,
    output logic [SELW-1:0]             sel_out,
    input  logic                        ready_out,
    output logic                        locked
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    logic [0:0]      r_state;
    logic [SELW-1:0] r_rr_ptr;
    logic [SELW-1:0] r_lock_idx;
    logic            r_valid_out;
    logic [DATAW-1:0] r_data_out;
    logic            r_sop_out;
    logic            r_eop_out;
    logic [SELW-1:0] r_sel_out;

    logic            w_stage_ready;
    logic            w_gnt_vld;
    logic [SELW-1:0] w_gnt_idx;
    logic [SELW:0]   w_scan;
    logic [DATAW-1:0] w_gnt_data;
    logic            w_gnt_sop;
    logic            w_gnt_eop;
    logic            w_fire;
    logic [SELW-1:0] w_next_ptr;

    // The output register can take a beat when empty or draining this cycle.
    assign w_stage_ready = !r_valid_out || ready_out;

    // Grant selection: locked owner only, otherwise first valid from rr_ptr.
    always_comb begin
        w_gnt_idx = '0;
        w_gnt_vld = 1'b0;
        w_scan    = '0;
        if (r_state == c_ST_LOCKED) begin
            w_gnt_idx = r_lock_idx;
            w_gnt_vld = valid_in[r_lock_idx];
        end else begin
            // Scan from the farthest offset down so the nearest valid wins.
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                w_scan = {1'b0, r_rr_ptr} + (SELW+1)'(k);
                if (w_scan >= (SELW+1)'(NUM_INPUTS)) begin
                    w_scan = w_scan - (SELW+1)'(NUM_INPUTS);
                end
                if (valid_in[w_scan[SELW-1:0]]) begin
                    w_gnt_idx = w_scan[SELW-1:0];
                    w_gnt_vld = 1'b1;
                end
            end
        end
    end

    // Mux the granted input's payload and framing.
    always_comb begin
        w_gnt_data = '0;
        w_gnt_sop  = 1'b0;
        w_gnt_eop  = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (w_gnt_idx == SELW'(i)) begin
                w_gnt_data = data_in[i*DATAW +: DATAW];
                w_gnt_sop  = sop_in[i];
                w_gnt_eop  = eop_in[i];
            end
        end
    end

    assign w_fire     = w_gnt_vld && w_stage_ready;
    assign w_next_ptr = (w_gnt_idx == SELW'(NUM_INPUTS - 1)) ? '0 : w_gnt_idx + 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_ready
            assign ready_in[gi] = w_gnt_vld && w_stage_ready && (w_gnt_idx == SELW'(gi));
        end
    endgenerate

    // Arbitration state: lock on a non-eop beat, release and rotate on eop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
        end else if (w_fire) begin
            if (w_gnt_eop) begin
                r_state  <= c_ST_IDLE;
                r_rr_ptr <= w_next_ptr;
            end else if (r_state == c_ST_IDLE) begin
                r_state    <= c_ST_LOCKED;
                r_lock_idx <= w_gnt_idx;
            end
        end
    end

    // Elastic output register: load on fire, clear when drained, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
            r_sop_out   <= 1'b0;
            r_eop_out   <= 1'b0;
            r_sel_out   <= '0;
        end else if (w_fire) begin
            r_valid_out <= 1'b1;
            r_data_out  <= w_gnt_data;
            r_sop_out   <= w_gnt_sop;
            r_eop_out   <= w_gnt_eop;
            r_sel_out   <= w_gnt_idx;
        end else if (ready_out) begin
            r_valid_out <= 1'b0;
        end
    end

    assign valid_out = r_valid_out;
    assign data_out  = r_data_out;
    assign sop_out   = r_sop_out;
    assign eop_out   = r_eop_out;
    assign sel_out   = r_sel_out;
    assign locked    = (r_state == c_ST_LOCKED);

endmodule
`default_nettype wire

// File: doc/commit_packet_arb.md
Name: commit_packet_arb

Overview:
- Packet-aware round-robin arbiter that merges NUM_INPUTS execution-unit commit streams (ALU/LSU/FPU/SFU) onto one writeback/commit stream per issue slice.
- Commit results may span several beats, delimited by sop/eop. Once a multi-beat packet starts, its grant is held until eop, so beats from different units never interleave on the writeback port.
- Sits between the per-unit commit interfaces and the commit/writeback stage.
- Output is registered: one elastic pipeline stage.

Parameters:
- NUM_INPUTS, 4, number of requesting units (>=1).
- DATAW, 64, payload width per input, excluding sop/eop.
- SELW, LOG2UP(NUM_INPUTS), width of the grant index.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- valid_in  in  NUM_INPUTS  per-input beat valid.
- data_in  in  NUM_INPUTS*DATAW  per-input payload; input i occupies bits [i*DATAW +: DATAW].
- sop_in  in  NUM_INPUTS  per-input start-of-packet.
- eop_in  in  NUM_INPUTS  per-input end-of-packet.
- ready_in  out  NUM_INPUTS  per-input accept.
- valid_out  out  1  output beat valid.
- data_out  out  DATAW  output payload.
- sop_out  out  1  output sop.
- eop_out  out  1  output eop.
- sel_out  out  SELW  index of the source of the current output beat.
- ready_out  in  1  downstream accept.
- locked  out  1  arbiter is mid-packet (state LOCKED).

Behaviour:
- Reset values: valid_out=0, data_out=0, sop_out=0, eop_out=0, sel_out=0, locked=0, state=IDLE, rr_ptr=0, lock_idx=0.
- stage_ready = !valid_out || ready_out.
- Input fire: fire_i = valid_in[i] && ready_in[i].
- ready_in[i] = grant[i] && stage_ready, combinational. At most one bit is set.
- ready_in must not depend on valid_in of other inputs beyond the arbitration itself (no combinational loop through ready_out to valid_in).
- Latency: an accepted beat appears on the outputs the next cycle. Throughput is 1 beat/cycle while ready_out=1.
- Output stage:
  - On fire: valid_out<=1, and data_out/sop_out/eop_out/sel_out are loaded from the granted input.
  - Else if ready_out: valid_out<=0.
  - Output data holds while valid_out && !ready_out.
- State IDLE:
  - grant = first valid input scanning rr_ptr, rr_ptr+1, ... mod NUM_INPUTS.
  - On fire with eop_in=1: stay IDLE; rr_ptr <= (granted+1) mod NUM_INPUTS.
  - On fire with eop_in=0: go to LOCKED; lock_idx <= granted.
  - sop_in is not checked in IDLE. Any first beat is treated as a packet start (protocol violation tolerated, not flagged).
- State LOCKED:
  - grant = lock_idx only, when valid_in[lock_idx]=1. Other inputs get ready_in=0 even if lock_idx is idle (bubbles allowed).
  - On fire with eop_in=1: go to IDLE; rr_ptr <= (lock_idx+1) mod NUM_INPUTS.
- locked = (state==LOCKED), registered.
- Single-beat packets (sop=eop=1) take one grant each and advance rr_ptr.
- Backpressure: while ready_out=0 and valid_out=1, no input fires; state and rr_ptr hold.
- Wrap-around: with rr_ptr = NUM_INPUTS-1, the scan continues at input 0.
- NUM_INPUTS=1: pass-through with one register stage; rr_ptr is constant 0.
- Reset asserted mid-packet: on the next edge, state=IDLE, any buffered beat is dropped (valid_out=0), rr_ptr=0. Upstream is reset together with this block.
- Simultaneous eop fire and new requests: the new rr_ptr applies from the next cycle. No same-cycle regrant.

Test Plan:
- Inputs 0..3 all valid with single-beat packets, ready_out=1 -> sel_out sequence 0,1,2,3,0,... Each beat appears 1 cycle after its ready_in, with no bubbles.
- Input 1 sends a 3-beat packet (sop,-,eop) while input 2 is continuously valid -> output carries beats 1a,1b,1c contiguously with locked=1 for 2 cycles, then input 2. ready_in[2]=0 throughout the packet.
- Input 1 mid-packet drops valid for 2 cycles while input 0 is valid -> 2 output bubbles, input 0 still not granted, packet resumes from input 1.
- ready_out held 0 for 3 cycles with valid_out=1 -> data_out/sel_out stable, all ready_in=0, rr_ptr unchanged. Flow resumes in the same order once ready_out=1.
- rr_ptr=3, valid_in=4'b1001 -> input 3 granted, then input 0 (wrap-around).
- reset pulsed while input 2 is locked mid-packet -> next cycle valid_out=0, locked=0; a following valid on input 0 is granted first.
